// File: rtl/data_memory.sv
// Register-based word-addressed data memory: combinational gated read, one-edge write latency.
// No backpressure; out-of-range accesses are flagged on addr_error and never touch the array.
module data_memory #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] write_data,
   input  logic              write_enable,
   input  logic              read_enable,
   output logic [DATA_W-1:0] read_data,
   output logic              addr_error
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic              wr_allow;
   logic              in_range;
   logic [IDX_W-1:0]  idx;

   // Any set bit above the index field is out of range; no aliasing.
   assign in_range = ((address >> IDX_W) == '0);
   assign idx      = address[IDX_W-1:0];

   // Reset release is retimed to clk so the first write lands on the second edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_allow <= 1'b0;
      end else begin
         wr_allow <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_allow && write_enable && in_range) begin
         mem[idx] <= write_data;
      end
   end

   always_comb begin
      read_data = '0;
      if (rst_n && read_enable && in_range) begin
         read_data = mem[idx];
      end
   end

   assign addr_error = rst_n && (write_enable || read_enable) && !in_range;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: directed cases followed by randomized traffic against an array model.
module tb_data_memory;

   localparam int DEPTH = 256;
   localparam int IDX_W = $clog2(DEPTH);

   logic        clk;
   logic        rst_n;
   logic [31:0] address;
   logic [31:0] write_data;
   logic        write_enable;
   logic        read_enable;
   logic [31:0] read_data;
   logic        addr_error;

   data_memory #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .address      (address),
      .write_data   (write_data),
      .write_enable (write_enable),
      .read_enable  (read_enable),
      .read_data    (read_data),
      .addr_error   (addr_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] rd;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   event        probe;
   int          tests = 0;
   int          fails = 0;
   logic [31:0] ref_mem [DEPTH];
   int          edges_since_rst = 0;

   // Edges seen with reset released; writes need at least one before them.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edges_since_rst <= 0;
      else        edges_since_rst <= edges_since_rst + 1;
   end

   always @(posedge clk) begin
      if (rst_n) begin
         assert (!$isunknown(write_enable))
         else $error("FAIL x_write_enable: write_enable=%b, required 0 or 1", write_enable);
      end
   end

   function automatic logic in_rng(input logic [31:0] a);
      return a < 32'(DEPTH);
   endfunction

   task automatic assert_reset();
      rst_n = 1'b0;
      foreach (ref_mem[i]) ref_mem[i] = '0;
   endtask

   task automatic tick();
      if (rst_n && edges_since_rst >= 1 && write_enable === 1'b1 && in_rng(address))
         ref_mem[address[IDX_W-1:0]] = write_data;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_val(input string n, input logic [31:0] rd, input logic err);
      exp_t e;
      e.name = n;
      e.rd   = rd;
      e.err  = err;
      sb.push_back(e);
      -> probe;
      #2;
   endtask

   task automatic expect_model(input string n);
      logic [31:0] rd;
      logic        err;
      rd  = (rst_n && read_enable && in_rng(address)) ? ref_mem[address[IDX_W-1:0]] : 32'h0;
      err = rst_n && (write_enable || read_enable) && !in_rng(address);
      expect_val(n, rd, err);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(probe);
         #1;
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL sb_underflow: output sampled with no expectation queued");
         end else begin
            e = sb.pop_front();
            if (read_data !== e.rd || addr_error !== e.err) begin
               fails++;
               $display("FAIL %s: read_data=%h addr_error=%b, required read_data=%h addr_error=%b",
                        e.name, read_data, addr_error, e.rd, e.err);
            end
         end
      end
   end

   initial begin : stimulus
      int r;
      rst_n        = 1'b0;
      write_enable = 1'b1;
      read_enable  = 1'b1;
      address      = 32'd300;
      write_data   = 32'h0;
      foreach (ref_mem[i]) ref_mem[i] = '0;
      #1;
      expect_val("reset_state", 32'h0, 1'b0);

      rst_n = 1'b1; address = 32'd7; write_data = 32'h1111;
      tick();
      expect_val("first_edge_blocked", 32'h0, 1'b0);
      tick();
      expect_val("second_edge_write", 32'h1111, 1'b0);

      address = 32'd5; write_data = 32'hDEADBEEF;
      tick();
      expect_val("preload", 32'hDEADBEEF, 1'b0);
      write_enable = 1'b0;
      assert_reset();
      #1;
      rst_n = 1'b1;
      expect_val("reset_clears", 32'h0, 1'b0);
      tick();

      write_enable = 1'b1; read_enable = 1'b0; address = 32'd0; write_data = 32'h1;
      tick();
      address = 32'd1; write_data = 32'h2;
      tick();
      write_enable = 1'b0; read_enable = 1'b1; address = 32'd0;
      expect_val("basic_rd0", 32'h1, 1'b0);
      address = 32'd1;
      expect_val("basic_rd1", 32'h2, 1'b0);

      write_enable = 1'b1; read_enable = 1'b0; address = 32'd0; write_data = 32'h1;
      tick();
      write_data = 32'h2;
      tick();
      write_enable = 1'b0; read_enable = 1'b1;
      expect_val("overwrite_held", 32'h2, 1'b0);

      read_enable = 1'b0; address = 32'd1;
      expect_val("read_gated", 32'h0, 1'b0);
      read_enable = 1'b1;
      expect_val("read_ungated", 32'h2, 1'b0);

      write_enable = 1'b1; read_enable = 1'b0; address = 32'd256; write_data = 32'hA5A5A5A5;
      expect_val("oor_write_flag", 32'h0, 1'b1);
      tick();
      write_enable = 1'b0; read_enable = 1'b1; address = 32'd0;
      expect_val("oor_no_alias0", 32'h2, 1'b0);
      address = 32'd256;
      expect_val("oor_read", 32'h0, 1'b1);
      write_enable = 1'b1; address = 32'h80000001;
      expect_val("oor_high_bit", 32'h0, 1'b1);
      tick();
      write_enable = 1'b0; address = 32'd1;
      expect_val("oor_no_alias1", 32'h2, 1'b0);
      read_enable = 1'b0; address = 32'd256;
      expect_val("oor_idle", 32'h0, 1'b0);

      write_enable = 1'b1; address = 32'd3; write_data = 32'd7;
      tick();
      write_data = 32'd9; read_enable = 1'b1;
      expect_val("rw_before_edge", 32'd7, 1'b0);
      tick();
      write_enable = 1'b0;
      expect_val("rw_after_edge", 32'd9, 1'b0);

      write_enable = 1'b1; read_enable = 1'b0; write_data = 32'h55;
      assert_reset();
      tick();
      rst_n = 1'b1; write_enable = 1'b0; read_enable = 1'b1;
      expect_val("reset_kills_write", 32'h0, 1'b0);

      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 49) == 0) begin
            assert_reset();
            #1;
            rst_n = 1'b1;
         end
         r = int'($urandom_range(0, 9));
         if (r < 7)      address = 32'($urandom_range(0, DEPTH - 1));
         else if (r < 9) address = 32'(DEPTH) + 32'($urandom_range(0, 3));
         else            address = $urandom | 32'h80000000;
         write_enable = 1'($urandom_range(0, 1));
         read_enable  = 1'($urandom_range(0, 1));
         write_data   = $urandom;
         expect_model("rand_pre");
         tick();
         write_enable = 1'b0;
         read_enable  = 1'b1;
         expect_model("rand_post");
      end

      for (int i = 0; i < 10 && sb.size() != 0; i++) #1;
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL sb_drain: %0d expectations left, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
